// File: rtl/load_store_unit_if.sv
// Data-memory request/acknowledge bus between the load/store unit and data memory.
interface load_store_unit_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/load_store_unit.sv
// Memory stage: one data-memory access per request, with byte-lane alignment for stores,
// extraction and sign/zero extension for loads, and fault reporting with the done pulse.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       is_load,
  input  logic                       is_store,
  input  logic [2:0]                 funct3,
  input  logic [31:0]                alu_result,
  input  logic [31:0]                rs2_data,
  output logic                       busy,
  output logic                       done,
  output logic [31:0]                load_data,
  output logic [1:0]                 fault,
  load_store_unit_if.master          dmem
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] FAULT_OK      = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [31:0]        load_data_q, load_data_d;
  logic [1:0]         fault_q, fault_d;
  logic               req_q, req_d;
  logic               we_q, we_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         be_q, be_d;
  logic [2:0]         funct3_q, funct3_d;
  logic [1:0]         off_q, off_d;
  logic               is_load_q, is_load_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;

  logic               illegal_c;
  logic               misaligned_c;
  logic [3:0]         be_c;
  logic [31:0]        st_wdata_c;
  logic [31:0]        shifted_c;
  logic [15:0]        half_c;
  logic [31:0]        ext_c;

  // Request decode: legality, alignment and lane placement of the incoming access.
  always_comb begin
    illegal_c    = is_load ? ((funct3 == 3'b011) || (funct3[2:1] == 2'b11))
                           : (funct3[2] || (funct3 == 3'b011));
    misaligned_c = ((funct3[1:0] == 2'b01) && alu_result[0]) ||
                   ((funct3[1:0] == 2'b10) && (alu_result[1:0] != 2'b00));
    be_c         = 4'b1111;
    st_wdata_c   = rs2_data;
    case (funct3[1:0])
      2'b00: begin
        be_c       = 4'b0001 << alu_result[1:0];
        st_wdata_c = {4{rs2_data[7:0]}};
      end
      2'b01: begin
        be_c       = alu_result[1] ? 4'b1100 : 4'b0011;
        st_wdata_c = {2{rs2_data[15:0]}};
      end
      default: begin
        be_c       = 4'b1111;
        st_wdata_c = rs2_data;
      end
    endcase
  end

  // Read-data lane selection and extension using the latched offset and width code.
  always_comb begin
    shifted_c = dmem.dmem_rdata >> {off_q, 3'b000};
    half_c    = off_q[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
    case (funct3_q)
      3'b000:  ext_c = {{24{shifted_c[7]}}, shifted_c[7:0]};
      3'b001:  ext_c = {{16{half_c[15]}}, half_c};
      3'b100:  ext_c = {24'd0, shifted_c[7:0]};
      3'b101:  ext_c = {16'd0, half_c};
      default: ext_c = dmem.dmem_rdata;
    endcase
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    done_d      = 1'b0;
    load_data_d = load_data_q;
    fault_d     = fault_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    is_load_d   = is_load_q;
    wait_cnt_d  = wait_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start && (is_load ^ is_store)) begin
          funct3_d  = funct3;
          off_d     = alu_result[1:0];
          is_load_d = is_load;
          if (illegal_c) begin
            state_d     = S_RESP;
            done_d      = 1'b1;
            fault_d     = FAULT_ILLEGAL;
            load_data_d = 32'd0;
          end else if (misaligned_c) begin
            state_d     = S_RESP;
            done_d      = 1'b1;
            fault_d     = FAULT_MISALIGN;
            load_data_d = 32'd0;
          end else begin
            state_d    = S_REQ;
            req_d      = 1'b1;
            we_d       = is_store;
            addr_d     = {alu_result[31:2], 2'b00};
            wdata_d    = is_store ? st_wdata_c : 32'd0;
            be_d       = be_c;
            wait_cnt_d = '0;
          end
        end
      end
      S_REQ: begin
        if (dmem.dmem_ack) begin
          state_d     = S_RESP;
          req_d       = 1'b0;
          done_d      = 1'b1;
          fault_d     = FAULT_OK;
          load_data_d = is_load_q ? ext_c : 32'd0;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
          // A zero timeout leaves the request waiting indefinitely.
          if ((TIMEOUT_CYCLES != 0) && (wait_cnt_q == CNT_LAST)) begin
            state_d     = S_RESP;
            req_d       = 1'b0;
            done_d      = 1'b1;
            fault_d     = FAULT_TIMEOUT;
            load_data_d = 32'd0;
          end
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      load_data_q <= 32'd0;
      fault_q     <= FAULT_OK;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      be_q        <= 4'b0000;
      funct3_q    <= 3'b000;
      off_q       <= 2'b00;
      is_load_q   <= 1'b0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      load_data_q <= load_data_d;
      fault_q     <= fault_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      is_load_q   <= is_load_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign load_data       = load_data_q;
  assign fault           = fault_q;
  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;
  assign dmem.dmem_be    = be_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a byte-level reference model of the access rules.
module tb_load_store_unit;

  localparam int unsigned TO = 4;

  logic        clk;
  logic        rst;
  logic        start;
  logic        is_load;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] alu_result;
  logic [31:0] rs2_data;
  logic        busy;
  logic        done;
  logic [31:0] load_data;
  logic [1:0]  fault;

  load_store_unit_if bus ();

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .is_load    (is_load),
    .is_store   (is_store),
    .funct3     (funct3),
    .alu_result (alu_result),
    .rs2_data   (rs2_data),
    .busy       (busy),
    .done       (done),
    .load_data  (load_data),
    .fault      (fault),
    .dmem       (bus)
  );

  int total = 0;
  int bad   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: access size in bytes from the width code.
  function automatic int unsigned size_of(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit is_illegal(input bit ld, input logic [2:0] f3);
    if (ld) return (f3 == 3) || (f3 == 6) || (f3 == 7);
    return f3 >= 3;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
    int unsigned sz = size_of(f3);
    int unsigned m  = ((1 << sz) - 1) << (addr % 4);
    return 4'(m);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] data);
    int unsigned sz = size_of(f3);
    logic [31:0] w = 32'd0;
    for (int i = 0; i < 4; i++) begin
      w = w | (((data >> (8 * (i % sz))) & 32'hFF) << (8 * i));
    end
    return w;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rd);
    int unsigned sz = size_of(f3);
    int unsigned v  = rd >> (8 * (addr % 4));
    if (sz < 4) begin
      v = v % (1 << (8 * sz));
      if (f3 < 4 && v >= (1 << (8 * sz - 1))) v = v - (1 << (8 * sz));
    end
    return v;
  endfunction

  task automatic run_txn(input bit ld, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] data, input logic [31:0] rd,
                         input int ack_cyc, input bit noise);
    int unsigned sz;
    logic [1:0]  exp_fault;
    int          exp_done;
    int          exp_reqs;
    int          ndone = 0;
    int          nreq  = 0;
    int          done_at = -1;
    logic [1:0]  got_fault = 2'b00;
    logic [31:0] got_ld = 32'd0;

    sz = size_of(f3);
    if (is_illegal(ld, f3)) begin
      exp_fault = 2'b11; exp_done = 1; exp_reqs = 0;
    end else if ((addr % sz) != 0) begin
      exp_fault = 2'b01; exp_done = 1; exp_reqs = 0;
    end else if (ack_cyc >= 1 && ack_cyc <= int'(TO)) begin
      exp_fault = 2'b00; exp_done = ack_cyc + 1; exp_reqs = ack_cyc;
    end else begin
      exp_fault = 2'b10; exp_done = int'(TO) + 1; exp_reqs = int'(TO);
    end

    start = 1'b1; is_load = ld; is_store = !ld; funct3 = f3;
    alu_result = addr; rs2_data = data; bus.dmem_ack = 1'b0;
    @(posedge clk); #1;

    for (int cyc = 1; cyc <= exp_done + 3; cyc++) begin
      start      = noise && (cyc <= exp_done) && ($urandom_range(0, 1) == 1);
      is_load    = 1'($urandom);
      is_store   = 1'($urandom);
      funct3     = 3'($urandom);
      alu_result = $urandom;
      rs2_data   = $urandom;
      bus.dmem_ack   = ((cyc == ack_cyc) && (exp_fault == 2'b00)) ||
                       (noise && (cyc == exp_done) && ($urandom_range(0, 1) == 1));
      bus.dmem_rdata = (cyc == ack_cyc) ? rd : $urandom;
      @(negedge clk);
      if (bus.dmem_req) begin
        nreq++;
        check_eq("addr",  bus.dmem_addr, addr & 32'hFFFF_FFFC);
        check_eq("we",    32'(bus.dmem_we), 32'(!ld));
        check_eq("be",    32'(bus.dmem_be), 32'(model_be(f3, addr)));
        check_eq("wdata", bus.dmem_wdata, ld ? 32'd0 : model_wdata(f3, data));
      end
      if (done) begin
        ndone++; done_at = cyc; got_fault = fault; got_ld = load_data;
      end
      if (cyc == 1)            check_eq("busy_c1", 32'(busy), 32'd1);
      if (cyc == exp_done + 1) check_eq("busy_after", 32'(busy), 32'd0);
      @(posedge clk); #1;
    end
    start = 1'b0;
    bus.dmem_ack = 1'b0;

    check_eq("done_cnt",  ndone, 1);
    check_eq("done_cyc",  done_at, exp_done);
    check_eq("fault",     32'(got_fault), 32'(exp_fault));
    check_eq("req_cycles", nreq, exp_reqs);
    if (exp_fault == 2'b00)
      check_eq("load_data", got_ld, ld ? model_load(f3, addr, rd) : 32'd0);
    else if (exp_fault == 2'b10)
      check_eq("load_data_to", got_ld, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = 3'b000;
    alu_result = 32'd0; rs2_data = 32'd0;
    bus.dmem_ack = 1'b0; bus.dmem_rdata = 32'd0;
    @(posedge clk); @(posedge clk); #1;
    @(negedge clk);
    check_eq("rst_busy",  32'(busy), 32'd0);
    check_eq("rst_done",  32'(done), 32'd0);
    check_eq("rst_fault", 32'(fault), 32'd0);
    check_eq("rst_ld",    load_data, 32'd0);
    check_eq("rst_req",   32'(bus.dmem_req), 32'd0);
    check_eq("rst_we",    32'(bus.dmem_we), 32'd0);
    check_eq("rst_addr",  bus.dmem_addr, 32'd0);
    check_eq("rst_wdata", bus.dmem_wdata, 32'd0);
    check_eq("rst_be",    32'(bus.dmem_be), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed scenarios
    run_txn(0, 3'b010, 32'h100, 32'hDEAD_BEEF, 32'd0, 1, 0);
    run_txn(1, 3'b000, 32'h103, 32'd0, 32'h8012_3456, 2, 0);
    run_txn(1, 3'b100, 32'h103, 32'd0, 32'h8012_3456, 1, 0);
    run_txn(0, 3'b001, 32'h202, 32'h0000_ABCD, 32'd0, 3, 0);
    run_txn(1, 3'b001, 32'h201, 32'd0, 32'd0, 1, 0);
    run_txn(1, 3'b010, 32'h300, 32'd0, 32'h1234_5678, 99, 0);
    run_txn(1, 3'b011, 32'h400, 32'd0, 32'd0, 1, 0);
    run_txn(1, 3'b101, 32'h502, 32'd0, 32'hF00D_8001, 4, 1);
    run_txn(0, 3'b000, 32'h601, 32'h0000_0077, 32'd0, 2, 1);

    // start with is_load == is_store is ignored
    start = 1'b1; is_load = 1'b1; is_store = 1'b1; funct3 = 3'b010; alu_result = 32'h10;
    @(posedge clk); #1;
    is_load = 1'b0; is_store = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("ign_busy", 32'(busy), 32'd0);
      check_eq("ign_done", 32'(done), 32'd0);
      check_eq("ign_req",  32'(bus.dmem_req), 32'd0);
      @(posedge clk); #1;
    end

    // Reset in the middle of a request
    begin
      int ndone = 0;
      start = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010; alu_result = 32'h40;
      @(posedge clk); #1;
      start = 1'b0;
      for (int cyc = 1; cyc <= 10; cyc++) begin
        rst = (cyc == 3);
        @(negedge clk);
        if (done) ndone++;
        if (cyc == 3) check_eq("rst_mid_req", 32'(bus.dmem_req), 32'd1);
        if (cyc == 4) begin
          check_eq("rst_post_req",  32'(bus.dmem_req), 32'd0);
          check_eq("rst_post_busy", 32'(busy), 32'd0);
        end
        @(posedge clk); #1;
      end
      rst = 1'b0;
      check_eq("rst_no_done", ndone, 0);
    end

    // Randomized traffic
    for (int n = 0; n < 200; n++) begin
      bit          ld   = 1'($urandom);
      logic [2:0]  f3   = 3'($urandom);
      logic [31:0] addr = $urandom;
      int          ack  = int'($urandom_range(1, TO + 2));
      bit          nz   = ($urandom_range(0, 3) == 0);
      run_txn(ld, f3, addr, $urandom, $urandom, ack, nz);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
